ring_step_monitor: RTL and testbench
====================================

Name: ring_step_monitor

Overview:
- Downstream consumer of the one-hot ring counter. Samples the ring counter's count bus every clock and checks that each step is a legal one-hot rotate-left.
- Locks onto a healthy sequence and converts the one-hot phase to a binary index.
- Counts complete laps, flags sequencing faults and holds the fault until software clears it.
- Used as the health/phase-decode stage between the ring counter and phase-driven logic.

Parameters:
- WIDTH, 4, ring width in bits; must match the ring counter; ≥2.
- LOCK_CNT, 3, consecutive legal steps required to enter LOCKED; ≥1.
- LAP_W, 8, width of the lap counter.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ring_in  input  WIDTH  one-hot count from the ring counter.
- clr_fault  input  1  synchronous fault clear, level-sampled.
- locked  output  1  sequence locked.
- fault  output  1  sticky sequencing fault.
- phase_idx  output  $clog2(WIDTH)  binary index of the active ring bit.
- wrap_pulse  output  1  one-cycle pulse on MSB→LSB wrap.
- lap_cnt  output  LAP_W  completed laps, modulo 2^LAP_W.
- err_cnt  output  ERR_W  faults detected, saturating at all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - Forces ring_q=0, prev_q=0, state=SEARCH, run_cnt=0.
  - Forces all outputs to 0.
  - Release of reset is synchronous to clk.
- Sampling:
  - Each edge: ring_q<=ring_in, then prev_q<=ring_q.
  - All outputs are registered. A ring_in value presented before edge k affects outputs after edge k+1 (2-cycle latency).
- Definitions (combinational on ring_q/prev_q):
  - onehot = exactly one bit of ring_q set.
  - step_ok = onehot && ring_q == rotl1(prev_q), where rotl1(1000)=0001.
  - wrap = step_ok && prev_q[WIDTH-1] && ring_q[0].
- FSM SEARCH:
  - locked=0.
  - On step_ok: run_cnt++. When run_cnt==LOCK_CNT-1 and step_ok, go to LOCKED and clear run_cnt.
  - On !step_ok: run_cnt<=0. This includes the 0000 seen while the ring counter is in reset.
  - No faults are raised in SEARCH; lap_cnt and phase_idx are frozen.
- FSM LOCKED:
  - locked=1.
  - On step_ok: phase_idx<=index(ring_q). On wrap, lap_cnt++ (wraps 2^LAP_W-1→0) and wrap_pulse=1 for exactly one cycle.
  - On !step_ok: go to FAULT, fault<=1, err_cnt++ (saturating), locked<=0, phase_idx held.
- FSM FAULT:
  - locked=0, fault=1. Ring activity is ignored; err_cnt does not increment again.
  - clr_fault=1: fault<=0, go to SEARCH, run_cnt<=0.
  - clr_fault=1 in the same cycle as a bad step: the clear wins; there is no re-fault until LOCKED is re-entered.
- clr_fault outside FAULT: no effect.
- wrap_pulse is 0 in SEARCH and FAULT.
- lap_cnt and err_cnt are cleared only by reset. A relock continues from the existing lap_cnt.
- Mid-operation reset: immediate clear of all state. Relock requires LOCK_CNT fresh legal steps after reset release.

Optional Feature:
- Macro: RING_MON_HOLD_EN.
- Defined: a legal hold (onehot && ring_q==prev_q) is accepted, so an enable-gated ring counter is supported.
  - LOCKED: stays LOCKED, no fault, no wrap, phase_idx unchanged.
  - SEARCH: run_cnt is held, neither incremented nor cleared.
- Undefined: a hold is !step_ok, i.e. a fault in LOCKED and a run_cnt clear in SEARCH.

Test Plan:
- Lock: rst low 2 cycles, release, then drive 0001,0010,0100,1000,0001… one per clock -> locked=1 after the 3rd legal step is registered, fault=0, err_cnt=0.
- Decode/wrap: once locked, drive the sequence through 1000→0001 -> phase_idx steps 0,1,2,3,0 with 2-cycle latency; wrap_pulse high exactly one cycle per lap; lap_cnt 0→1→2 over 8 steps.
- Fault/clear: while locked, inject 0110 -> fault=1, locked=0, err_cnt=1.
  - Hold clr_fault=0 for 10 cycles -> state unchanged.
  - Pulse clr_fault with legal ring -> fault=0, locked=1 again after 3 steps, lap_cnt preserved.
- Async reset mid-LOCKED: drop rst between edges -> locked, fault, phase_idx, lap_cnt and err_cnt read 0 before the next clk edge.
- Hold feature: while locked, drive 0100 for 3 cycles -> with RING_MON_HOLD_EN, locked stays 1 and fault=0; without it, fault=1 and err_cnt=1.
- Counter limits:
  - 256 laps -> lap_cnt wraps 255→0 with wrap_pulse.
  - 16 fault/clear/relock cycles -> err_cnt saturates at 15.

Source files
------------

// File: rtl/ring_step_monitor.sv
// ring_step_monitor: health and phase-decode stage behind a one-hot ring counter.
// Samples the ring bus every clock and checks that each step is a legal
// rotate-left. After LOCK_CNT consecutive legal steps it locks and converts the
// active bit to a binary index. It also counts completed laps and records
// sequencing faults, which stay set until clr_fault is asserted.
// Optional feature macro: RING_MON_HOLD_EN. When defined, a repeated one-hot
// value (an enable-gated ring that holds) is accepted as a legal step.
module ring_step_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LAP_W    = 8,
  parameter int unsigned ERR_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clr_fault,
  output logic                     locked,
  output logic                     fault,
  output logic [$clog2(WIDTH)-1:0] phase_idx,
  output logic                     wrap_pulse,
  output logic [LAP_W-1:0]         lap_cnt,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ring_q, prev_q;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               locked_q, locked_d;
  logic               fault_q, fault_d;
  logic [IDX_W-1:0]   phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic [LAP_W-1:0]   lap_q, lap_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               onehot;
  logic               step_ok;
  logic               hold_ok;
  logic               wrap;
  logic [IDX_W-1:0]   ring_idx;

  assign onehot  = (ring_q != '0) && ((ring_q & (ring_q - 1'b1)) == '0);
  assign step_ok = onehot && (ring_q == {prev_q[WIDTH-2:0], prev_q[WIDTH-1]});
  assign wrap    = step_ok && prev_q[WIDTH-1] && ring_q[0];

`ifdef RING_MON_HOLD_EN
  assign hold_ok = onehot && (ring_q == prev_q);
`else
  assign hold_ok = 1'b0;
`endif

  // Binary index of the single set bit of ring_q.
  always_comb begin
    ring_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ring_q[i]) ring_idx = ring_idx | IDX_W'(i);
    end
  end

  // Next-state and registered-output logic for the SEARCH/LOCKED/FAULT FSM.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    phase_d = phase_q;
    lap_d   = lap_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    case (state_q)
      SEARCH: begin
        if (step_ok) begin
          if (run_q == RUN_W'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end else if (!hold_ok) begin
          run_d = '0;
        end
      end
      LOCKED: begin
        if (step_ok) begin
          phase_d = ring_idx;
          if (wrap) begin
            lap_d  = lap_q + 1'b1;
            wrap_d = 1'b1;
          end
        end else if (!hold_ok) begin
          state_d = FAULT;
          if (err_q != '1) err_d = err_q + 1'b1;
        end
      end
      FAULT: begin
        if (clr_fault) begin
          state_d = SEARCH;
          run_d   = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);
    fault_d  = (state_d == FAULT);
  end

  // Input sampling pipeline, FSM state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_q   <= '0;
      prev_q   <= '0;
      state_q  <= SEARCH;
      run_q    <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      phase_q  <= '0;
      wrap_q   <= 1'b0;
      lap_q    <= '0;
      err_q    <= '0;
    end else begin
      ring_q   <= ring_in;
      prev_q   <= ring_q;
      state_q  <= state_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      phase_q  <= phase_d;
      wrap_q   <= wrap_d;
      lap_q    <= lap_d;
      err_q    <= err_d;
    end
  end

  assign locked     = locked_q;
  assign fault      = fault_q;
  assign phase_idx  = phase_q;
  assign wrap_pulse = wrap_q;
  assign lap_cnt    = lap_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_ring_step_monitor.sv
// Testbench for ring_step_monitor: a randomized plus directed ring sequence,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
module tb_ring_step_monitor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ring_in;
  logic         clr_fault;
  logic         locked, fault, wrap_pulse;
  logic [1:0]   phase_idx;
  logic [7:0]   lap_cnt;
  logic [3:0]   err_cnt;

  typedef struct packed {
    logic       lk;
    logic       ft;
    logic [1:0] ph;
    logic       wp;
    logic [7:0] lap;
    logic [3:0] err;
  } obs_t;

  obs_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: last two sampled values and abstract monitor status.
  int m_ring, m_prev, m_mode, m_run, m_phase, m_lap, m_err;
  int cur, last;

  ring_step_monitor #(.WIDTH(W), .LOCK_CNT(3), .LAP_W(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .clr_fault(clr_fault),
    .locked(locked), .fault(fault), .phase_idx(phase_idx),
    .wrap_pulse(wrap_pulse), .lap_cnt(lap_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int rot(input int p);
    return ((p * 2) % (1 << W)) + (p / (1 << (W - 1)));
  endfunction

  task automatic push_zero();
    obs_t e;
    e = '0;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_ring = 0; m_prev = 0; m_mode = 0; m_run = 0;
    m_phase = 0; m_lap = 0; m_err = 0;
  endtask

  // Mode 0 = searching, 1 = locked, 2 = faulted.
  task automatic model_step(input int v, input bit clr);
    obs_t e;
    bit legal, hold, wr;
    legal = ($countones(m_ring) == 1) && (m_ring == rot(m_prev));
`ifdef RING_MON_HOLD_EN
    hold = ($countones(m_ring) == 1) && (m_ring == m_prev);
`else
    hold = 1'b0;
`endif
    wr = 1'b0;
    if (m_mode == 0) begin
      if (legal) begin
        m_run++;
        if (m_run == 3) begin m_mode = 1; m_run = 0; end
      end else if (!hold) m_run = 0;
    end else if (m_mode == 1) begin
      if (legal) begin
        m_phase = $clog2(m_ring);
        if (m_prev == (1 << (W - 1)) && m_ring == 1) begin
          m_lap = (m_lap + 1) % 256;
          wr = 1'b1;
        end
      end else if (!hold) begin
        m_mode = 2;
        if (m_err < 15) m_err++;
      end
    end else begin
      if (clr) begin m_mode = 0; m_run = 0; end
    end
    e.lk = (m_mode == 1); e.ft = (m_mode == 2);
    e.ph = 2'(m_phase); e.wp = wr;
    e.lap = 8'(m_lap); e.err = 4'(m_err);
    sb.push_back(e);
    m_prev = m_ring;
    m_ring = v;
  endtask

  task automatic drive(input int v, input bit clr);
    @(negedge clk);
    ring_in = W'(v);
    clr_fault = clr;
    last = v;
    model_step(v, clr);
  endtask

  task automatic legal_steps(input int n);
    repeat (n) begin drive(cur, 1'b0); cur = rot(cur); end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    sb.delete();
    model_reset();
    push_zero();
    repeat (n - 1) begin @(negedge clk); push_zero(); end
    @(negedge clk);
    rst = 1'b1;
    ring_in = '0;
    clr_fault = 1'b0;
    last = 0;
    model_step(0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a registered output word; compare it.
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = {locked, fault, phase_idx, wrap_pulse, lap_cnt, err_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got lk=%b ft=%b ph=%0d wp=%b lap=%0d err=%0d exp lk=%b ft=%b ph=%0d wp=%b lap=%0d err=%0d",
                   $time, got.lk, got.ft, got.ph, got.wp, got.lap, got.err,
                   e.lk, e.ft, e.ph, e.wp, e.lap, e.err);
        end
      end
    end
  end

  initial begin
    ring_in = '0;
    clr_fault = 1'b0;
    cur = 1;
    do_reset(2);

    // Lock and decode through several laps.
    legal_steps(12);
    // Fault injection, clr held low, then clear and relock.
    drive(4'b0110, 1'b0);
    legal_steps(10);
    drive(cur, 1'b1); cur = rot(cur);
    legal_steps(8);
    // Hold the ring value for three cycles.
    repeat (3) drive(last, 1'b0);
    legal_steps(3);
    drive(cur, 1'b1); cur = rot(cur);
    legal_steps(8);
    // 256+ laps to wrap lap_cnt.
    legal_steps(1028);
    // Repeated fault/clear/relock to saturate err_cnt.
    repeat (16) begin
      drive(0, 1'b0);
      legal_steps(2);
      drive(cur, 1'b1); cur = rot(cur);
      legal_steps(7);
    end
    // Randomized traffic: mostly legal, with holds, junk and stray clears.
    repeat (3000) begin
      int r, v;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 9) == 0);
      if (r < 85) begin v = cur; cur = rot(cur); end
      else if (r < 92) v = last;
      else begin
        v = $urandom_range(0, (1 << W) - 1);
        if ($countones(v) == 1) cur = rot(v);
      end
      drive(v, c);
    end
    // Clear any fault, relock, then reset asynchronously between edges.
    drive(cur, 1'b1); cur = rot(cur);
    legal_steps(10);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({locked, fault, phase_idx, lap_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL async_rst got lk=%b ft=%b ph=%0d lap=%0d err=%0d exp all 0",
               locked, fault, phase_idx, lap_cnt, err_cnt);
    end
    do_reset(2);
    cur = 1;
    legal_steps(10);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
